// File: rtl/dm_arbiter_if.sv
// Request/response and DataMemory bundle for dm_arbiter.
// The slave modport faces the arbiter; the master modport faces the requesters and the memory.
interface dm_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port DataMemory; each accept is a 2-cycle access.
// Define DM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority with a port-1 starvation limit.
module dm_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
`ifndef DM_ARB_ROUND_ROBIN_EN
  ,
  parameter int STARVE_LIM = 3
`endif
) (
  input  logic          clk,
  input  logic          reset,
  dm_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e            r_state;
  logic              r_owner;
  logic              r_busy;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rvalid0, r_rvalid1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  logic w_any_req;
  logic w_win1;
  logic w_gnt0, w_gnt1;

`ifdef DM_ARB_ROUND_ROBIN_EN
  logic r_last_gnt;
`else
  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);
  logic [SW-1:0] r_starve_cnt;
`endif

  assign w_any_req = bus.req0 | bus.req1;

  // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    w_win1 = 1'b0;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
    w_win1 = bus.req1 & (~bus.req0 | ~r_last_gnt);
`else
    w_win1 = bus.req1 & (~bus.req0 | (r_starve_cnt == LIM));
`endif
    if (r_state == IDLE && !reset) begin
      w_gnt1 = w_win1;
      w_gnt0 = bus.req0 & ~w_win1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
`ifdef DM_ARB_ROUND_ROBIN_EN
      r_last_gnt  <= 1'b1;
`else
      r_starve_cnt <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_rvalid0 <= 1'b0;
          r_rvalid1 <= 1'b0;
          r_mem_we  <= 1'b0;
          if (w_any_req) begin
            r_state     <= ACCESS;
            r_busy      <= 1'b1;
            r_owner     <= w_win1;
            r_mem_addr  <= w_win1 ? bus.addr1  : bus.addr0;
            r_mem_wdata <= w_win1 ? bus.wdata1 : bus.wdata0;
            r_mem_we    <= w_win1 ? bus.we1    : bus.we0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            r_last_gnt  <= w_win1;
`else
            if (w_win1 || !bus.req1)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != LIM)
              r_starve_cnt <= r_starve_cnt + 1'b1;
`endif
          end
        end
        ACCESS: begin
          // Memory writes on this edge when mem_we is set; reads capture the combinational data_out.
          if (!r_mem_we) begin
            if (r_owner) r_rdata1 <= bus.mem_rdata;
            else         r_rdata0 <= bus.mem_rdata;
          end
          r_rvalid0 <= ~r_owner;
          r_rvalid1 <= r_owner;
          r_mem_we  <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = w_gnt0;
  assign bus.gnt1      = w_gnt1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.busy      = r_busy;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural DataMemory (sync write, combinational read).
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  dm_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dm_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    tick();
    n_cmp++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, bus.mem_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got gnt/rv/busy/we=%b want 000000",
               {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.busy, bus.mem_we});
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%0d wdata=%0d rdata0=%0d rdata1=%0d want 0",
               bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1);
    end
    apply_reset();
  endtask

  task automatic test_write_read();
    apply_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10'd12; bus.wdata0 = 32'd154851;
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b100) begin
      n_err++; $display("FAIL wr_gnt: got gnt0,gnt1,busy=%b want 100", {bus.gnt0, bus.gnt1, bus.busy});
    end
    tick();
    bus.req0 = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.mem_we, bus.gnt0} !== 3'b110 || bus.mem_addr !== 10'd12 ||
        bus.mem_wdata !== 32'd154851) begin
      n_err++;
      $display("FAIL wr_access: got busy,we,gnt0=%b addr=%0d wdata=%0d want 110 12 154851",
               {bus.busy, bus.mem_we, bus.gnt0}, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    n_cmp++;
    if ({bus.rvalid0, bus.busy, bus.mem_we} !== 3'b100 || bus.rdata0 !== 32'd0) begin
      n_err++;
      $display("FAIL wr_done: got rvalid0,busy,we=%b rdata0=%0d want 100 0",
               {bus.rvalid0, bus.busy, bus.mem_we}, bus.rdata0);
    end
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'd12;
    #1;
    n_cmp++;
    if (bus.gnt0 !== 1'b1) begin
      n_err++; $display("FAIL rd_gnt_with_rvalid: got gnt0=%b want 1", bus.gnt0);
    end
    tick();
    bus.req0 = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.mem_we, bus.rvalid0} !== 3'b100 || bus.mem_addr !== 10'd12) begin
      n_err++;
      $display("FAIL rd_access: got busy,we,rvalid0=%b addr=%0d want 100 12",
               {bus.busy, bus.mem_we, bus.rvalid0}, bus.mem_addr);
    end
    tick();
    n_cmp++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'd154851) begin
      n_err++;
      $display("FAIL rd_data: got rvalid0=%b rdata0=%0d want 1 154851", bus.rvalid0, bus.rdata0);
    end
    tick();
    n_cmp++;
    if (bus.rvalid0 !== 1'b0) begin
      n_err++; $display("FAIL rvalid_pulse: got rvalid0=%b want 0", bus.rvalid0);
    end
  endtask

  task automatic test_both_req();
    apply_reset();
    bus.req0 = 1'b1; bus.addr0 = 10'd10;
    bus.req1 = 1'b1; bus.addr1 = 10'd12;
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_err++; $display("FAIL both_first: got gnt0,gnt1=%b want 10", {bus.gnt0, bus.gnt1});
    end
    tick();
    bus.req0 = 1'b0;
    n_cmp++;
    if (bus.mem_addr !== 10'd10 || bus.gnt1 !== 1'b0) begin
      n_err++; $display("FAIL both_acc0: got addr=%0d gnt1=%b want 10 0", bus.mem_addr, bus.gnt1);
    end
    tick();
    n_cmp++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h1000_000A || bus.gnt1 !== 1'b1) begin
      n_err++;
      $display("FAIL both_rv0: got rvalid0=%b rdata0=%h gnt1=%b want 1 1000000a 1",
               bus.rvalid0, bus.rdata0, bus.gnt1);
    end
    tick();
    bus.req1 = 1'b0;
    n_cmp++;
    if (bus.mem_addr !== 10'd12 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL both_acc1: got addr=%0d busy=%b want 12 1", bus.mem_addr, bus.busy);
    end
    tick();
    n_cmp++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'd154851 || bus.rvalid0 !== 1'b0) begin
      n_err++;
      $display("FAIL both_rv1: got rvalid1=%b rdata1=%0d rvalid0=%b want 1 154851 0",
               bus.rvalid1, bus.rdata1, bus.rvalid0);
    end
  endtask

  // Both ports hold requests; want[k] is the winner of the k-th arbitration.
  task automatic run_contention(input logic [7:0] want, input string tag);
    logic prev;
    apply_reset();
    bus.req0 = 1'b1; bus.addr0 = 10'd1;
    bus.req1 = 1'b1; bus.addr1 = 10'd2;
    prev = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if ({bus.gnt1, bus.gnt0} !== (want[k] ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL %s_gnt%0d: got gnt1,gnt0=%b want %b", tag, k, {bus.gnt1, bus.gnt0},
                 want[k] ? 2'b10 : 2'b01);
      end
      if (k > 0) begin
        n_cmp++;
        if ({bus.rvalid1, bus.rvalid0} !== (prev ? 2'b10 : 2'b01)) begin
          n_err++;
          $display("FAIL %s_rv%0d: got rvalid1,rvalid0=%b want %b", tag, k,
                   {bus.rvalid1, bus.rvalid0}, prev ? 2'b10 : 2'b01);
        end
      end
      prev = want[k];
      tick();
      tick();
    end
    drive_idle();
  endtask

  task automatic test_starvation();
`ifdef DM_ARB_ROUND_ROBIN_EN
    run_contention(8'b1010_1010, "rr");
`else
    run_contention(8'b1000_1000, "starve");
`endif
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 10'd10; bus.wdata1 = 32'd1351515;
    #1;
    n_cmp++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      n_err++; $display("FAIL rst_gnt1: got gnt0,gnt1=%b want 01", {bus.gnt0, bus.gnt1});
    end
    tick();
    bus.req1 = 1'b0;
    n_cmp++;
    if (bus.mem_we !== 1'b1) begin
      n_err++; $display("FAIL rst_pre_we: got mem_we=%b want 1", bus.mem_we);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.mem_we, bus.busy, bus.rvalid1, bus.gnt1} !== 4'b0 || bus.mem_addr !== 10'd0 ||
        bus.mem_wdata !== 32'd0 || bus.rdata1 !== 32'd0) begin
      n_err++;
      $display("FAIL rst_async: got we,busy,rv1,gnt1=%b addr=%0d wdata=%0d rdata1=%0d want 0000 0 0 0",
               {bus.mem_we, bus.busy, bus.rvalid1, bus.gnt1}, bus.mem_addr, bus.mem_wdata, bus.rdata1);
    end
    tick();
    tick();
    n_cmp++;
    if (bus.rvalid1 !== 1'b0) begin
      n_err++; $display("FAIL rst_rv_lost: got rvalid1=%b want 0", bus.rvalid1);
    end
    reset = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'd10;
    tick();
    bus.req1 = 1'b0;
    tick();
    n_cmp++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'h1000_000A) begin
      n_err++;
      $display("FAIL rst_old_val: got rvalid1=%b rdata1=%h want 1 1000000a", bus.rvalid1, bus.rdata1);
    end
  endtask

  task automatic test_idle_hold();
    drive_idle();
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++;
      if ({bus.gnt0, bus.gnt1, bus.mem_we, bus.busy} !== 4'b0 || bus.mem_addr !== 10'd10) begin
        n_err++;
        $display("FAIL idle%0d: got gnt0,gnt1,we,busy=%b addr=%0d want 0000 10", k,
                 {bus.gnt0, bus.gnt1, bus.mem_we, bus.busy}, bus.mem_addr);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
    drive_idle();
    test_reset();
    test_write_read();
    test_both_req();
    test_starvation();
    test_reset_mid_access();
    test_idle_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
